// File: rtl/gearbox_push_arbiter.sv
// Burst-locked round-robin arbiter that feeds the narrow push port of a gearbox FIFO.
// Each grant owns the port for exactly BEAT_NUM accepted words, and each completed wide word emits a source tag.
module gearbox_push_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int BEAT_NUM   = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic                          push_req_out,
  output logic [DATA_WIDTH-1:0]         push_data_out,
  input  logic                          full_in,
  output logic [NUM_REQ-1:0]            grant_out,
  output logic [ID_WIDTH-1:0]           grant_id_out,
  output logic                          busy_out,
  output logic                          tag_valid_out,
  output logic [ID_WIDTH-1:0]           tag_id_out
);

  localparam int CNT_WIDTH = $clog2(BEAT_NUM);
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BEAT_NUM - 1);
  localparam logic [ID_WIDTH-1:0]  LAST_REQ  = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state, state_next;
  logic [ID_WIDTH-1:0]   owner, owner_next;
  logic [ID_WIDTH-1:0]   last_id, last_id_next;
  logic [CNT_WIDTH-1:0]  beat_cnt, beat_cnt_next;
  logic                  tag_valid, tag_valid_next;
  logic [ID_WIDTH-1:0]   tag_id, tag_id_next;

  logic                  busy;
  logic                  any_pick;
  logic [ID_WIDTH-1:0]   pick_id;
  logic                  owner_valid;
  logic [DATA_WIDTH-1:0] owner_data;
  int                    idx;

  assign busy = (state == BURST);

  // Scan from the farthest candidate back to last_id+1 so the nearest valid index wins.
  always_comb begin
    any_pick = 1'b0;
    pick_id  = '0;
    idx      = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_id) + k) % NUM_REQ;
      if (req_valid_in[idx]) begin
        any_pick = 1'b1;
        pick_id  = ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    owner_valid   = 1'b0;
    owner_data    = '0;
    req_ready_out = '0;
    grant_out     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == ID_WIDTH'(i)) begin
        owner_valid      = req_valid_in[i];
        owner_data       = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready_out[i] = busy & ~full_in;
        grant_out[i]     = busy;
      end
    end
  end

  assign push_req_out  = busy & owner_valid & ~full_in;
  assign push_data_out = busy ? owner_data : '0;
  assign busy_out      = busy;
  assign grant_id_out  = owner;
  assign tag_valid_out = tag_valid;
  assign tag_id_out    = tag_id;

  always_comb begin
    state_next     = state;
    owner_next     = owner;
    last_id_next   = last_id;
    beat_cnt_next  = beat_cnt;
    tag_valid_next = 1'b0;
    tag_id_next    = tag_id;
    case (state)
      IDLE: begin
        if (any_pick && !full_in) begin
          state_next    = BURST;
          owner_next    = pick_id;
          last_id_next  = pick_id;
          beat_cnt_next = '0;
        end
      end
      BURST: begin
        // Stalls simply hold everything; the lock is released only by the final beat.
        if (push_req_out) begin
          if (beat_cnt == LAST_BEAT) begin
            state_next     = IDLE;
            beat_cnt_next  = '0;
            tag_valid_next = 1'b1;
            tag_id_next    = owner;
          end else begin
            beat_cnt_next = beat_cnt + CNT_WIDTH'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      last_id   <= LAST_REQ;
      beat_cnt  <= '0;
      tag_valid <= 1'b0;
      tag_id    <= '0;
    end else begin
      state     <= state_next;
      owner     <= owner_next;
      last_id   <= last_id_next;
      beat_cnt  <= beat_cnt_next;
      tag_valid <= tag_valid_next;
      tag_id    <= tag_id_next;
    end
  end

endmodule

// File: tb/tb_gearbox_push_arbiter.sv
// Randomized bench for gearbox_push_arbiter, compared cycle by cycle against a burst-level reference model.
module tb_gearbox_push_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 16;
  localparam int BEAT_NUM   = 4;
  localparam int ID_WIDTH   = $clog2(NUM_REQ);

  logic                          clk;
  logic                          rst;
  logic [NUM_REQ-1:0]            req_valid_in;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in;
  logic [NUM_REQ-1:0]            req_ready_out;
  logic                          push_req_out;
  logic [DATA_WIDTH-1:0]         push_data_out;
  logic                          full_in;
  logic [NUM_REQ-1:0]            grant_out;
  logic [ID_WIDTH-1:0]           grant_id_out;
  logic                          busy_out;
  logic                          tag_valid_out;
  logic [ID_WIDTH-1:0]           tag_id_out;

  int check_count = 0;
  int error_count = 0;

  // Reference model: who owns the port, how many words of the burst are done, who won last.
  bit m_busy;
  int m_owner;
  int m_beats;
  int m_last;
  bit m_tag_valid;
  int m_tag_id;

  gearbox_push_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .BEAT_NUM(BEAT_NUM), .ID_WIDTH(ID_WIDTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_in(req_valid_in), .req_data_in(req_data_in), .req_ready_out(req_ready_out),
    .push_req_out(push_req_out), .push_data_out(push_data_out), .full_in(full_in),
    .grant_out(grant_out), .grant_id_out(grant_id_out), .busy_out(busy_out),
    .tag_valid_out(tag_valid_out), .tag_id_out(tag_id_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_busy      = 1'b0;
    m_owner     = 0;
    m_beats     = 0;
    m_last      = NUM_REQ - 1;
    m_tag_valid = 1'b0;
    m_tag_id    = 0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy_out), 64'(0));
    checkOutput({tag, "_grant"}, 64'(grant_out), 64'(0));
    checkOutput({tag, "_grant_id"}, 64'(grant_id_out), 64'(0));
    checkOutput({tag, "_ready"}, 64'(req_ready_out), 64'(0));
    checkOutput({tag, "_push"}, 64'(push_req_out), 64'(0));
    checkOutput({tag, "_data"}, 64'(push_data_out), 64'(0));
    checkOutput({tag, "_tag_valid"}, 64'(tag_valid_out), 64'(0));
    checkOutput({tag, "_tag_id"}, 64'(tag_id_out), 64'(0));
  endtask

  // Drive one cycle of inputs, check the outputs the model predicts, then advance the model past the clock edge.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic full);
    logic [DATA_WIDTH-1:0] words [NUM_REQ];
    logic [NUM_REQ-1:0]    exp_grant;
    bit                    exp_push;
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      words[i] = DATA_WIDTH'($urandom);
      req_data_in[i*DATA_WIDTH +: DATA_WIDTH] = words[i];
    end
    req_valid_in = valid;
    full_in      = full;
    #1;
    exp_grant = '0;
    if (m_busy) exp_grant[m_owner] = 1'b1;
    exp_push = m_busy && valid[m_owner] && !full;
    checkOutput("busy", 64'(busy_out), 64'(m_busy));
    checkOutput("grant", 64'(grant_out), 64'(exp_grant));
    if (m_busy) checkOutput("grant_id", 64'(grant_id_out), 64'(m_owner));
    checkOutput("push_req", 64'(push_req_out), 64'(exp_push));
    checkOutput("ready", 64'(req_ready_out), (m_busy && !full) ? 64'(exp_grant) : 64'(0));
    checkOutput("push_data", 64'(push_data_out), m_busy ? 64'(words[m_owner]) : 64'(0));
    checkOutput("tag_valid", 64'(tag_valid_out), 64'(m_tag_valid));
    if (m_tag_valid) checkOutput("tag_id", 64'(tag_id_out), 64'(m_tag_id));

    m_tag_valid = 1'b0;
    if (m_busy) begin
      if (exp_push) begin
        m_beats++;
        if (m_beats == BEAT_NUM) begin
          m_busy      = 1'b0;
          m_tag_valid = 1'b1;
          m_tag_id    = m_owner;
        end
      end
    end else if (valid != '0 && !full) begin
      for (int step = 1; step <= NUM_REQ; step++) begin
        int cand;
        cand = (m_last + step) % NUM_REQ;
        if (valid[cand]) begin
          m_owner = cand;
          m_last  = cand;
          m_beats = 0;
          m_busy  = 1'b1;
          break;
        end
      end
    end
  endtask

  initial begin
    bit reached;
    rst          = 1'b1;
    req_valid_in = '0;
    req_data_in  = '0;
    full_in      = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #2;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Everyone requesting at full rate: round-robin order and one-bubble spacing.
    repeat (30) applyStimulus('1, 1'b0);

    // Full asserted while requests wait must hold off the grant.
    repeat (4) applyStimulus(4'b0110, 1'b1);
    repeat (12) applyStimulus(4'b0110, 1'b0);

    for (int n = 0; n < 1500; n++) begin
      logic [NUM_REQ-1:0] v;
      for (int i = 0; i < NUM_REQ; i++) v[i] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) v = '0;
      applyStimulus(v, $urandom_range(0, 4) == 0);
    end

    // Reset landing in the middle of a burst clears everything without waiting for a clock.
    reached = 1'b0;
    for (int n = 0; n < 40 && !reached; n++) begin
      applyStimulus('1, 1'b0);
      if (m_busy && m_beats == 1) reached = 1'b1;
    end
    checkOutput("reach_mid_burst", 64'(reached), 64'(1));
    @(posedge clk);
    #2;
    checkOutput("mid_burst_busy", 64'(busy_out), 64'(1));
    rst = 1'b1;
    #1;
    checkAllZero("mid_reset");
    modelReset();
    req_valid_in = '0;
    full_in      = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    repeat (20) applyStimulus('1, 1'b0);
    for (int n = 0; n < 300; n++) applyStimulus(NUM_REQ'($urandom), $urandom_range(0, 3) == 0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/gearbox_push_arbiter.md
# gearbox_push_arbiter

Round-robin arbiter that shares the narrow push port of a gearbox FIFO (narrow-in, wide-out mode) among NUM_REQ requesters. Grants are burst-locked: once a requester wins, it owns the port for exactly BEAT_NUM accepted words, so every wide output word is packed from a single source. A source-tag strobe is emitted per completed wide word, so the pop side can route it.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- DATA_WIDTH, 16, narrow word width; equals gearbox input width
- BEAT_NUM, 4, narrow words per wide word; equals gearbox FIFO count (≥2)
- ID_WIDTH, $clog2(NUM_REQ), requester index width

Ports (one clock `clk`; reset `rst` is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid_in  in  NUM_REQ  per-requester word valid
- req_data_in  in  NUM_REQ×DATA_WIDTH  per-requester word (packed, index i at [i*DATA_WIDTH +: DATA_WIDTH])
- req_ready_out  out  NUM_REQ  word accepted when valid&ready
- push_req_out  out  1  to gearbox push_req_in
- push_data_out  out  DATA_WIDTH  to gearbox data_in
- full_in  in  1  from gearbox full_out
- grant_out  out  NUM_REQ  one-hot current owner, 0 when idle
- grant_id_out  out  ID_WIDTH  owner index (valid when busy_out)
- busy_out  out  1  burst in progress
- tag_valid_out  out  1  1-cycle pulse: wide word completed
- tag_id_out  out  ID_WIDTH  source of completed wide word

## Operation
- States: IDLE, BURST. Registers: state, owner (ID_WIDTH), beat_cnt ($clog2(BEAT_NUM) bits), last_id, tag_valid, tag_id.
- IDLE: if any req_valid_in and !full_in, pick the first valid index searching last_id+1, last_id+2, … modulo NUM_REQ; next cycle state=BURST, owner=winner, last_id=winner, beat_cnt=0. Otherwise stay IDLE. No pushes or readies in IDLE.
- BURST (combinational outputs): req_ready_out[owner]=!full_in, all others 0; push_data_out=req_data_in[owner]; push_req_out=req_valid_in[owner]&!full_in. Accept = push_req_out.
- On accept: if beat_cnt==BEAT_NUM-1, then state→IDLE, beat_cnt→0, tag_valid=1 and tag_id=owner next cycle; else beat_cnt+1.
- Owner valid low or full_in high mid-burst: stall, hold state/beat_cnt; no re-arbitration until the burst completes (lock is unconditional; sources must finish bursts).
- Requests from non-owners are ignored during BURST; they compete at the next IDLE.
- push_data_out = 0 when not BURST.
- Gearbox pointer alignment: arbiter and gearbox must share reset; beat_cnt tracks gearbox write pointer exactly since only this block pushes.

## Timing
- Reset values: state=IDLE, last_id=NUM_REQ-1 (requester 0 highest priority first), owner=0, beat_cnt=0; all outputs 0 (grant_out=0, busy_out=0, req_ready_out=0, push_req_out=0, tag_valid_out=0, tag_id_out=0).
- Arbitration latency: 1 cycle (request seen in IDLE at cycle t → first possible accept at t+1).
- Full-rate burst: BEAT_NUM accepts in BEAT_NUM consecutive cycles; one IDLE bubble between bursts → throughput BEAT_NUM/(BEAT_NUM+1).
- tag_valid_out: registered, asserted for exactly 1 cycle, the cycle after the final accept (coincides with the IDLE bubble).
- full_in is sampled combinationally; gearbox full is per-current-lane, so a stall may occur on any beat.
- grant_out/grant_id_out/busy_out are registered (derived from state/owner).
- Reset mid-burst: immediate return to reset values; partial wide word is the gearbox's concern (also reset).

## Test plan
- Single source: req_valid_in=4'b0001, words A0..A3, full_in=0 → IDLE one cycle, then push_req_out high 4 consecutive cycles with A0..A3, tag_valid_out pulse with tag_id_out=0 the following cycle.
- Round-robin: all four valid continuously → bursts granted in order 0,1,2,3,0; each burst exactly 4 pushes; tag_id sequence 0,1,2,3,0.
- Backpressure: requester 2 bursting, full_in=1 on beat 1 for 3 cycles → req_ready_out=0 and push_req_out=0 those cycles, beat_cnt held; completes with 4 total pushes, data order intact.
- Owner gap + contention: owner 1 drops valid after beat 2 for 5 cycles while requester 3 valid → grant stays at 1, no pushes from 3; after beat 3, next grant goes to 3.
- Full at idle: full_in=1 with requests pending → stays IDLE, grant_out=0; deassert full → grant next cycle.
- Reset mid-burst: assert rst after beat 1 → all outputs 0 asynchronously; after release, requester 0 wins first if valid.
